wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_fifo.sv | 39 +++
 rtl/wb_unit.sv | 69 ++++++
 tb/tb_wb_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback widths, defaults and request type
package wb_pkg;
    localparam int XLEN_DEF = 32;
    localparam int REG_AW = 5;
    localparam int LSU_DEPTH_DEF = 2;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with wrapping pointers, push/pop/full/empty
module wb_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic full,
    output logic empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rdata = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
            if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/wb_unit.sv
// wb_unit: EXU/LSU writeback arbiter with load buffer and pending-load scoreboard
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int LSU_DEPTH = LSU_DEPTH_DEF
) (
    input logic clk,
    input logic rst,
    input logic exu_valid,
    input logic [REG_AW-1:0] exu_rd,
    input logic [XLEN-1:0] exu_data,
    input logic lsu_valid,
    output logic lsu_ready,
    input logic [REG_AW-1:0] lsu_rd,
    input logic [XLEN-1:0] lsu_data,
    input logic issue_valid,
    input logic [REG_AW-1:0] issue_rd,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0] in_data,
    output logic [31:0] busy
);
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0] data;
    } req_t;
    req_t exu_req, lsu_req, head, sel;
    logic full, empty, acc, push, pop, sel_lsu, sel_valid;
    logic [31:0] busy_next;
    assign exu_req = '{rd: exu_rd, data: exu_data};
    assign lsu_req = '{rd: lsu_rd, data: lsu_data};
    assign lsu_ready = !rst && !full;
    assign acc = lsu_valid && lsu_ready;
    // An accepted load bypasses the buffer only when nothing older is queued and EXU is idle
    always_comb begin
        pop = !exu_valid && !empty;
        push = acc && (exu_valid || !empty);
        sel_lsu = !exu_valid && (!empty || acc);
        sel_valid = exu_valid || sel_lsu;
        sel = exu_valid ? exu_req : (!empty ? head : lsu_req);
    end
    wb_fifo #(.W($bits(req_t)), .DEPTH(LSU_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wdata(lsu_req),
        .rdata(head),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        busy_next = busy;
        if (sel_lsu) busy_next[sel.rd] = 1'b0;
        if (issue_valid) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
            in_data <= '0;
            busy <= '0;
        end else begin
            rd <= sel_valid ? sel.rd : '0;
            if (sel_valid && sel.rd != '0) in_data <= sel.data;
            busy <= busy_next;
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: scoreboard bench for wb_unit
module tb_wb_unit;
    import wb_pkg::*;
    logic clk = 1'b0;
    logic rst, exu_valid, lsu_valid, lsu_ready, issue_valid;
    logic [4:0] exu_rd, lsu_rd, issue_rd, rd;
    logic [31:0] exu_data, lsu_data, in_data, busy;
    int total = 0;
    int bad = 0;
    wb_req_t exp_q[$];
    wb_req_t e;

    wb_unit dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rd(rd), .in_data(in_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exu_valid = 0;
        lsu_valid = 0;
        issue_valid = 0;
    endtask

    always @(negedge clk)
        if (rd != 0) begin
            if (exp_q.size() == 0) chk("unexpected_wr", {59'd0, rd}, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("wr_rd", {59'd0, rd}, {59'd0, e.rd});
                chk("wr_data", {32'd0, in_data}, {32'd0, e.data});
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int ld;
        logic accepted;
        rst = 1; idle(); exu_valid = 1; exu_rd = 9; exu_data = 32'h1234_5678;
        lsu_rd = 0; lsu_data = 0; issue_rd = 0;
        step(); step();
        chk("rst_rd", {59'd0, rd}, 64'd0);
        chk("rst_data", {32'd0, in_data}, 64'd0);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, lsu_ready}, 64'd0);
        rst = 0; exu_valid = 0;
        step();
        chk("ready_after_rst", {63'd0, lsu_ready}, 64'd1);
        chk("no_wr_after_rst", {59'd0, rd}, 64'd0);

        exu_valid = 1; exu_rd = 2; exu_data = 32'hf0f0feec;
        exp_q.push_back('{rd: 5'd2, data: 32'hf0f0feec});
        step(); idle();
        chk("exu_rd", {59'd0, rd}, 64'd2);
        chk("exu_data", {32'd0, in_data}, 64'hf0f0feec);
        step();
        chk("exu_rd_gone", {59'd0, rd}, 64'd0);
        chk("exu_data_hold", {32'd0, in_data}, 64'hf0f0feec);

        exu_valid = 1; exu_rd = 0; exu_data = 32'hdeadbeef;
        step(); idle();
        chk("x0_exu_rd", {59'd0, rd}, 64'd0);
        chk("x0_exu_hold", {32'd0, in_data}, 64'hf0f0feec);
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1357_9bdf;
        step(); idle();
        chk("x0_lsu_rd", {59'd0, rd}, 64'd0);
        chk("x0_lsu_hold", {32'd0, in_data}, 64'hf0f0feec);

        exu_valid = 1; exu_rd = 3; exu_data = 32'h0ecccccc;
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hfff00000;
        exp_q.push_back('{rd: 5'd3, data: 32'h0ecccccc});
        exp_q.push_back('{rd: 5'd5, data: 32'hfff00000});
        #1 chk("coll_ready", {63'd0, lsu_ready}, 64'd1);
        step(); idle();
        chk("coll_first", {59'd0, rd}, 64'd3);
        step();
        chk("coll_second", {59'd0, rd}, 64'd5);
        chk("coll_second_data", {32'd0, in_data}, 64'hfff00000);
        step();
        chk("coll_done", {59'd0, rd}, 64'd0);

        for (int c = 0; c < 3; c++) exp_q.push_back('{rd: 5'(10 + c), data: 32'h1000_0000 + 32'(c)});
        for (int c = 0; c < 3; c++) exp_q.push_back('{rd: 5'(20 + c), data: 32'h2000_0000 + 32'(c)});
        ld = 0;
        for (int c = 0; c < 12 && (ld < 3 || c < 3); c++) begin
            exu_valid = c < 3; exu_rd = 5'(10 + c); exu_data = 32'h1000_0000 + 32'(c);
            lsu_valid = ld < 3; lsu_rd = 5'(20 + ld); lsu_data = 32'h2000_0000 + 32'(ld);
            #1;
            if (c < 2) chk("fill_ready", {63'd0, lsu_ready}, 64'd1);
            if (c == 2) chk("full_ready", {63'd0, lsu_ready}, 64'd0);
            accepted = lsu_valid && lsu_ready;
            step();
            if (accepted) ld++;
        end
        idle();
        chk("loads_accepted", 64'(ld), 64'd3);
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) step();
        step();
        chk("drain", 64'(exp_q.size()), 64'd0);

        issue_valid = 1; issue_rd = 7;
        step(); issue_valid = 0;
        chk("busy_set", {32'd0, busy}, 64'h80);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h7777_0001;
        issue_valid = 1; issue_rd = 7;
        exp_q.push_back('{rd: 5'd7, data: 32'h7777_0001});
        step(); idle();
        chk("busy_set_wins", {32'd0, busy}, 64'h80);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h7777_0002;
        exp_q.push_back('{rd: 5'd7, data: 32'h7777_0002});
        step(); idle();
        chk("busy_clear", {32'd0, busy}, 64'h0);
        issue_valid = 1; issue_rd = 4;
        step();
        issue_rd = 0;
        step(); idle();
        chk("busy_x0", {32'd0, busy}, 64'h10);
        exu_valid = 1; exu_rd = 4; exu_data = 32'h4444_4444;
        exp_q.push_back('{rd: 5'd4, data: 32'h4444_4444});
        step(); idle();
        chk("busy_exu_untouched", {32'd0, busy}, 64'h10);

        exu_valid = 1; exu_rd = 13; exu_data = 32'h1313_1313;
        lsu_valid = 1; lsu_rd = 23; lsu_data = 32'h2323_2323;
        exp_q.push_back('{rd: 5'd13, data: 32'h1313_1313});
        step();
        idle(); rst = 1;
        step();
        chk("midrst_busy", {32'd0, busy}, 64'h0);
        rst = 0;
        step();
        chk("midrst_no_wr", {59'd0, rd}, 64'd0);
        step();
        chk("midrst_discard", {59'd0, rd}, 64'd0);
        step();
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
